seq_capture64: RTL

- Start-triggered 64-sample window capture buffer with a streaming readout.
- On start it writes one din word per clock for exactly 64 consecutive cycles into a local store.
- It then drains the 64 words in index order over a valid/ready interface.
- Sits between the 64-cycle acquisition sequencing and the downstream consumer; it is the reading end of the 64-step window.

---
 rtl/seq_capture_pkg.sv | 15 +
 rtl/seq_capture64_cap_store.sv | 25 ++
 rtl/seq_capture64.sv | 103 ++++++++++
 3 files changed

// File: rtl/seq_capture_pkg.sv
// Shared types and sizing for the 64-sample window capture buffer.
`timescale 1ns/1ps
package seq_capture_pkg;

  localparam int CAP_DEPTH = 64;
  localparam int CAP_IDX_W = 6;
  localparam int CAP_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seq_capture64_cap_store.sv
// DEPTH x WIDTH flop store: one synchronous write port, one asynchronous read port.
`timescale 1ns/1ps
module cap_store #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; every word is written before it is read in a window.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/seq_capture64.sv
// Start-triggered 64-sample window capture with in-order valid/ready readout.
`timescale 1ns/1ps
module seq_capture64
  import seq_capture_pkg::*;
#(
  parameter  int WIDTH = CAP_WIDTH,
  parameter  int DEPTH = CAP_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic [IDX_W-1:0] cap_idx,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  cap_state_e       state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             done_q, done_d;
  logic             we;

  cap_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_store (
    .clk   (clk),
    .we    (we),
    .waddr (wr_idx_q),
    .wdata (din),
    .raddr (rd_idx_q),
    .rdata (dout)
  );

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    done_d   = 1'b0;
    we       = 1'b0;

    if (abort) begin
      // A transfer on this edge counts as consumed, but the window never completes.
      state_d  = IDLE;
      wr_idx_d = '0;
      rd_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = CAPTURE;
        end
        CAPTURE: begin
          we       = 1'b1;
          wr_idx_d = wr_idx_q + IDX_W'(1);
          if (wr_idx_q == LAST_IDX) state_d = DRAIN;
        end
        DRAIN: begin
          if (dout_ready) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            if (rd_idx_q == LAST_IDX) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      done_q   <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign cap_idx    = (state_q == CAPTURE) ? wr_idx_q : '0;
  assign dout_valid = (state_q == DRAIN);
  assign dout_last  = dout_valid && (rd_idx_q == LAST_IDX);
  assign done       = done_q;

endmodule
